clut_loader: RTL and testbench
==============================

CLUT_LOADER -- requirements
Module: clut_loader

Interface
REQ-001 Parameters: none; burst length is fixed at 8 x 32-bit words (16 colors) per memory request.
REQ-002 i_clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_loadReq  in  1  one-cycle load command (driven from cache o_needLoading).
REQ-005 i_CLUT_ID  in  15  CLUT position: [5:0] X in 16-pixel units, [14:6] Y line.
REQ-006 i_is8bpp  in  1  1 = 256-color CLUT (16 bursts), 0 = 16-color CLUT (1 burst).
REQ-007 o_busy  out  1  load in progress.
REQ-008 o_done  out  1  one-cycle pulse after last cache write.
REQ-009 o_memReq  out  1  burst read request, held until accepted.
REQ-010 o_memAddr  out  18  32-bit VRAM word address of burst, 8-word aligned.
REQ-011 i_memAck  in  1  request accepted this cycle.
REQ-012 i_memValid  in  1  read data beat valid.
REQ-013 i_memData  in  32  read data, two 16-bit colors, low halfword = even index.
REQ-014 o_write  out  1  cache write strobe.
REQ-015 o_writeIdx128  out  7  cache word index (color pair index).
REQ-016 o_Colors  out  32  cache write data.

Function
REQ-017 States: IDLE, REQ, RECV, DONE; o_busy high in REQ, RECV, DONE.
REQ-018 IDLE: on i_loadReq, latch i_CLUT_ID and i_is8bpp, clear burst counter (4 bits) and beat counter (3 bits), go REQ.
REQ-019 i_loadReq while o_busy is ignored; no re-latch, no restart.
REQ-020 REQ: o_memReq=1, o_memAddr = {Y, (X + burst) mod 64, 3'b000}; on i_memAck go RECV next cycle.
REQ-021 X field wraps modulo 64 within the same Y line; Y never increments.
REQ-022 o_memAddr stable while o_memReq high and not acknowledged.
REQ-023 RECV: each i_memValid beat increments beat counter; i_memValid outside RECV is ignored.
REQ-024 Cache write registered: cycle after a valid beat, o_write=1, o_Colors=beat data, o_writeIdx128={burst, beat}.
REQ-025 On 8th beat: if burst is last (0 for 4bpp, 15 for 8bpp) go DONE, else increment burst, go REQ.
REQ-026 DONE: lasts one cycle, coincides with final o_write; o_done=1; then IDLE.
REQ-027 A 4bpp load writes indices 0..7 only; an 8bpp load writes 0..127 in ascending order; each index exactly once.
REQ-028 Latency: i_loadReq to first o_memReq = 1 cycle; last beat to o_done = 1 cycle.
REQ-029 i_loadReq on the DONE cycle is ignored; accepted from the following IDLE cycle.

Reset
REQ-030 i_rst forces IDLE; o_busy, o_done, o_memReq, o_write = 0; o_memAddr, o_writeIdx128, o_Colors, counters = 0.
REQ-031 Reset mid-operation aborts the load; beats arriving after reset produce no o_write.
REQ-032 i_rst has priority over i_loadReq in the same cycle.

Structure
REQ-033 Shared GPU package holds: CLUT_ID field widths (X 6, Y 9), burst length 8, cache index width 7, VRAM word address width 18.
REQ-034 Single flat module; no sub-modules; FSM encoded as a package enum.

Verification
REQ-035 4bpp, ID Y=10 X=3: o_memAddr=5144 after 1 cycle; ack; 8 beats 0x00010000+n -> writes idx 0..7 with matching data, o_done on cycle after beat 8.
REQ-036 8bpp, ID Y=2 X=60: burst addresses 1504,1512,1520,1528 then wrap to 1024 (X=0) ... 1112; 128 writes idx 0..127; single o_done.
REQ-037 Memory withholds i_memAck 5 cycles -> o_memReq and o_memAddr held constant; no writes.
REQ-038 Second i_loadReq with different ID mid-load -> ignored; addresses continue from first ID.
REQ-039 i_rst after 3rd beat of burst 2 (8bpp) -> IDLE next cycle; remaining beats produce no o_write; new load then proceeds normally from burst 0.
REQ-040 Gapped beats (i_memValid toggling 1/0) -> writes occur only cycle after each valid beat, indices contiguous.

Source files
------------

// File: rtl/clut_loader_pkg.sv
// -----------------------------------------------------------------------------
// clut_loader_pkg
// Shared GPU definitions used by the CLUT loader: CLUT_ID field widths, VRAM
// burst geometry, cache index width, the loader FSM state encoding and the
// burst address helper.
// -----------------------------------------------------------------------------
package clut_loader_pkg;

   // CLUT_ID layout: [5:0] X in 16-pixel units, [14:6] Y line
   localparam int CLUT_X_W    = 6;
   localparam int CLUT_Y_W    = 9;
   localparam int CLUT_ID_W   = CLUT_X_W + CLUT_Y_W;

   // One burst = 8 x 32-bit words = 16 colors
   localparam int BURST_LEN   = 8;
   localparam int BEAT_W      = 3;
   localparam int BURST_W     = 4;

   // Cache holds 128 color pairs; VRAM is addressed in 32-bit words
   localparam int CACHE_IDX_W = 7;
   localparam int VRAM_ADDR_W = 18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } clutState_t;

   // Word address of a burst: X advances by one 16-pixel block per burst and
   // wraps inside the 6-bit field, so the load never spills onto the next line.
   function automatic logic [VRAM_ADDR_W-1:0] burstAddr(
      input logic [CLUT_ID_W-1:0] clutId,
      input logic [BURST_W-1:0]   burst
   );
      logic [CLUT_X_W-1:0] x;
      x = clutId[CLUT_X_W-1:0] + {2'b00, burst};
      return {clutId[CLUT_ID_W-1:CLUT_X_W], x, 3'b000};
   endfunction

endpackage

// File: rtl/clut_loader.sv
// -----------------------------------------------------------------------------
// clut_loader
// Fetches a CLUT from VRAM and writes it into the CLUT cache, one 32-bit color
// pair per cache write. A 4bpp CLUT is one 8-word burst, an 8bpp CLUT is 16
// bursts. All outputs are registered.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_loadReq      one-cycle load command (ignored while busy)
//   i_CLUT_ID      [5:0] X in 16-pixel units, [14:6] Y line
//   i_is8bpp       1 = 256-color CLUT, 0 = 16-color CLUT
//   o_busy         load in progress
//   o_done         one-cycle pulse together with the final cache write
//   o_memReq       burst read request, held until i_memAck
//   o_memAddr      VRAM word address of the burst (8-word aligned)
//   i_memAck       request accepted this cycle
//   i_memValid     read data beat valid
//   i_memData      two 16-bit colors, low halfword = even index
//   o_write        cache write strobe
//   o_writeIdx128  cache word index {burst, beat}
//   o_Colors       cache write data
// -----------------------------------------------------------------------------
module clut_loader
   import clut_loader_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_loadReq,
   input  logic [CLUT_ID_W-1:0]   i_CLUT_ID,
   input  logic                   i_is8bpp,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_memReq,
   output logic [VRAM_ADDR_W-1:0] o_memAddr,
   input  logic                   i_memAck,
   input  logic                   i_memValid,
   input  logic [31:0]            i_memData,
   output logic                   o_write,
   output logic [CACHE_IDX_W-1:0] o_writeIdx128,
   output logic [31:0]            o_Colors
);

   clutState_t             state_r,    stateNext_s;
   logic [BURST_W-1:0]     burst_r,    burstNext_s;
   logic [BEAT_W-1:0]      beat_r,     beatNext_s;
   logic [CLUT_ID_W-1:0]   clutId_r,   clutIdNext_s;
   logic                   is8bpp_r,   is8bppNext_s;

   logic                   busy_r,     busyNext_s;
   logic                   done_r,     doneNext_s;
   logic                   memReq_r,   memReqNext_s;
   logic [VRAM_ADDR_W-1:0] memAddr_r,  memAddrNext_s;
   logic                   write_r,    writeNext_s;
   logic [CACHE_IDX_W-1:0] writeIdx_r, writeIdxNext_s;
   logic [31:0]            colors_r,   colorsNext_s;

   logic [BURST_W-1:0]     lastBurst_s;

   // Last burst index depends on the latched color depth
   always_comb begin
      if (is8bpp_r) begin
         lastBurst_s = 4'd15;
      end else begin
         lastBurst_s = 4'd0;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that they can be driven straight from flops.
   always_comb begin
      stateNext_s    = state_r;
      burstNext_s    = burst_r;
      beatNext_s     = beat_r;
      clutIdNext_s   = clutId_r;
      is8bppNext_s   = is8bpp_r;
      doneNext_s     = 1'b0;
      memReqNext_s   = 1'b0;
      memAddrNext_s  = memAddr_r;
      writeNext_s    = 1'b0;
      writeIdxNext_s = writeIdx_r;
      colorsNext_s   = colors_r;

      case (state_r)
         ST_IDLE: begin
            if (i_loadReq) begin
               clutIdNext_s  = i_CLUT_ID;
               is8bppNext_s  = i_is8bpp;
               burstNext_s   = 4'd0;
               beatNext_s    = 3'd0;
               memReqNext_s  = 1'b1;
               memAddrNext_s = burstAddr(i_CLUT_ID, 4'd0);
               stateNext_s   = ST_REQ;
            end else begin
               stateNext_s   = ST_IDLE;
            end
         end

         ST_REQ: begin
            // Address is left untouched so it stays stable until the ack
            if (i_memAck) begin
               memReqNext_s = 1'b0;
               stateNext_s  = ST_RECV;
            end else begin
               memReqNext_s = 1'b1;
               stateNext_s  = ST_REQ;
            end
         end

         ST_RECV: begin
            if (i_memValid) begin
               writeNext_s    = 1'b1;
               writeIdxNext_s = {burst_r, beat_r};
               colorsNext_s   = i_memData;
               beatNext_s     = beat_r + 3'd1;
               if (beat_r == 3'd7) begin
                  if (burst_r == lastBurst_s) begin
                     doneNext_s  = 1'b1;
                     stateNext_s = ST_DONE;
                  end else begin
                     burstNext_s   = burst_r + 4'd1;
                     memReqNext_s  = 1'b1;
                     memAddrNext_s = burstAddr(clutId_r, burst_r + 4'd1);
                     stateNext_s   = ST_REQ;
                  end
               end else begin
                  stateNext_s = ST_RECV;
               end
            end else begin
               stateNext_s = ST_RECV;
            end
         end

         ST_DONE: begin
            // A load command arriving here is deliberately dropped
            stateNext_s = ST_IDLE;
         end

         default: begin
            stateNext_s = ST_IDLE;
         end
      endcase

      busyNext_s = (stateNext_s != ST_IDLE);
   end

   // State, counters, latched request and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         burst_r    <= 4'd0;
         beat_r     <= 3'd0;
         clutId_r   <= 15'd0;
         is8bpp_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         memReq_r   <= 1'b0;
         memAddr_r  <= 18'd0;
         write_r    <= 1'b0;
         writeIdx_r <= 7'd0;
         colors_r   <= 32'd0;
      end else begin
         state_r    <= stateNext_s;
         burst_r    <= burstNext_s;
         beat_r     <= beatNext_s;
         clutId_r   <= clutIdNext_s;
         is8bpp_r   <= is8bppNext_s;
         busy_r     <= busyNext_s;
         done_r     <= doneNext_s;
         memReq_r   <= memReqNext_s;
         memAddr_r  <= memAddrNext_s;
         write_r    <= writeNext_s;
         writeIdx_r <= writeIdxNext_s;
         colors_r   <= colorsNext_s;
      end
   end

   assign o_busy        = busy_r;
   assign o_done        = done_r;
   assign o_memReq      = memReq_r;
   assign o_memAddr     = memAddr_r;
   assign o_write       = write_r;
   assign o_writeIdx128 = writeIdx_r;
   assign o_Colors      = colors_r;

endmodule

// File: tb/tb_clut_loader.sv
// -----------------------------------------------------------------------------
// tb_clut_loader
// Directed self-checking bench for clut_loader. Inputs change 1 time unit
// after the rising edge, outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_clut_loader;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_loadReq;
   logic [14:0] i_CLUT_ID;
   logic        i_is8bpp;
   logic        o_busy;
   logic        o_done;
   logic        o_memReq;
   logic [17:0] o_memAddr;
   logic        i_memAck;
   logic        i_memValid;
   logic [31:0] i_memData;
   logic        o_write;
   logic [6:0]  o_writeIdx128;
   logic [31:0] o_Colors;

   int checks   = 0;
   int failures = 0;
   int writesSeen = 0;
   int donesSeen  = 0;

   logic [17:0] addrTbl [16];

   clut_loader dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_loadReq     (i_loadReq),
      .i_CLUT_ID     (i_CLUT_ID),
      .i_is8bpp      (i_is8bpp),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_memReq      (o_memReq),
      .o_memAddr     (o_memAddr),
      .i_memAck      (i_memAck),
      .i_memValid    (i_memValid),
      .i_memData     (i_memData),
      .o_write       (o_write),
      .o_writeIdx128 (o_writeIdx128),
      .o_Colors      (o_Colors)
   );

   // Clock generation
   always #5 i_clk = ~i_clk;

   // Pulse counters for cache writes and done strobes
   always @(negedge i_clk) begin
      if (o_write) writesSeen <= writesSeen + 1;
      if (o_done)  donesSeen  <= donesSeen + 1;
   end

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic startLoad(input logic [14:0] id, input logic is8);
      i_CLUT_ID = id;
      i_is8bpp  = is8;
      i_loadReq = 1'b1;
      step();
      i_loadReq = 1'b0;
   endtask

   // Serves one burst: optional ack delay (with an optional intruding load
   // command), eight beats (optionally with idle cycles between them)
   task automatic runBurst(input string tag, input logic [17:0] expAddr,
                           input logic [6:0] idxBase, input logic [31:0] dataBase,
                           input bit gapped, input int ackDelay,
                           input bit intruder, input bit isLast);
      int waitCyc;
      waitCyc = 0;
      while (!o_memReq && waitCyc < 20) begin
         step();
         waitCyc++;
      end
      chk({tag, "_req"}, {31'd0, o_memReq}, 32'd1);
      chk({tag, "_addr"}, {14'd0, o_memAddr}, {14'd0, expAddr});
      for (int d = 0; d < ackDelay; d++) begin
         if (intruder && d == 1) begin
            i_CLUT_ID = {9'd1, 6'd1};
            i_is8bpp  = 1'b1;
            i_loadReq = 1'b1;
         end
         step();
         i_loadReq = 1'b0;
         chk({tag, "_holdReq"}, {31'd0, o_memReq}, 32'd1);
         chk({tag, "_holdAddr"}, {14'd0, o_memAddr}, {14'd0, expAddr});
         chk({tag, "_holdNoWr"}, {31'd0, o_write}, 32'd0);
      end
      i_memAck = 1'b1;
      step();
      i_memAck = 1'b0;
      chk({tag, "_reqDrop"}, {31'd0, o_memReq}, 32'd0);
      for (int n = 0; n < 8; n++) begin
         i_memValid = 1'b1;
         i_memData  = dataBase + 32'(n);
         step();
         i_memValid = 1'b0;
         i_memData  = 32'd0;
         chk({tag, "_wr"}, {31'd0, o_write}, 32'd1);
         chk({tag, "_idx"}, {25'd0, o_writeIdx128}, {25'd0, idxBase} + 32'(n));
         chk({tag, "_data"}, o_Colors, dataBase + 32'(n));
         chk({tag, "_done"}, {31'd0, o_done}, {31'd0, (isLast && n == 7)});
         if (gapped && n < 7) begin
            step();
            chk({tag, "_gapNoWr"}, {31'd0, o_write}, 32'd0);
         end
      end
   endtask

   initial begin
      int w0;
      int d0;
      addrTbl = '{18'd1504, 18'd1512, 18'd1520, 18'd1528, 18'd1024, 18'd1032,
                  18'd1040, 18'd1048, 18'd1056, 18'd1064, 18'd1072, 18'd1080,
                  18'd1088, 18'd1096, 18'd1104, 18'd1112};
      i_rst      = 1'b1;
      i_loadReq  = 1'b0;
      i_CLUT_ID  = 15'd0;
      i_is8bpp   = 1'b0;
      i_memAck   = 1'b0;
      i_memValid = 1'b0;
      i_memData  = 32'd0;
      step();
      step();
      i_rst = 1'b0;

      // Reset state
      chk("rst_busy",  {31'd0, o_busy},   32'd0);
      chk("rst_done",  {31'd0, o_done},   32'd0);
      chk("rst_req",   {31'd0, o_memReq}, 32'd0);
      chk("rst_addr",  {14'd0, o_memAddr}, 32'd0);
      chk("rst_wr",    {31'd0, o_write},  32'd0);
      chk("rst_idx",   {25'd0, o_writeIdx128}, 32'd0);
      chk("rst_color", o_Colors, 32'd0);

      // 4bpp load, Y=10 X=3 -> word address 5144
      w0 = writesSeen;
      d0 = donesSeen;
      startLoad({9'd10, 6'd3}, 1'b0);
      chk("t1_busy", {31'd0, o_busy}, 32'd1);
      runBurst("t1", 18'd5144, 7'd0, 32'h0001_0000, 1'b0, 0, 1'b0, 1'b1);
      chk("t1_busyDone", {31'd0, o_busy}, 32'd1);
      // load command on the DONE cycle must be dropped
      i_CLUT_ID = {9'd4, 6'd4};
      i_loadReq = 1'b1;
      step();
      i_loadReq = 1'b0;
      chk("t1_idleBusy", {31'd0, o_busy}, 32'd0);
      chk("t1_idleDone", {31'd0, o_done}, 32'd0);
      chk("t1_idleReq",  {31'd0, o_memReq}, 32'd0);
      step();
      chk("t1_noRestart", {31'd0, o_memReq}, 32'd0);
      chk("t1_writes", 32'(writesSeen - w0), 32'd8);
      chk("t1_dones",  32'(donesSeen - d0),  32'd1);

      // 8bpp load, Y=2 X=60: X wraps within the line; burst 3 gapped
      w0 = writesSeen;
      d0 = donesSeen;
      startLoad({9'd2, 6'd60}, 1'b1);
      for (int b = 0; b < 16; b++) begin
         runBurst("t2", addrTbl[b], 7'(b * 8), 32'hA000_0000 + 32'(b * 256),
                  (b == 3), 0, 1'b0, (b == 15));
      end
      step();
      chk("t2_idle",   {31'd0, o_busy}, 32'd0);
      chk("t2_writes", 32'(writesSeen - w0), 32'd128);
      chk("t2_dones",  32'(donesSeen - d0),  32'd1);

      // Withheld ack plus an intruding load command; Y=300 X=63 -> 154104
      w0 = writesSeen;
      startLoad({9'd300, 6'd63}, 1'b0);
      runBurst("t3", 18'd154104, 7'd0, 32'h5555_AAA0, 1'b0, 5, 1'b1, 1'b1);
      step();
      chk("t3_idle",   {31'd0, o_busy}, 32'd0);
      chk("t3_req",    {31'd0, o_memReq}, 32'd0);
      chk("t3_writes", 32'(writesSeen - w0), 32'd8);

      // 8bpp Y=5 X=0, reset after the 3rd beat of burst 2
      startLoad({9'd5, 6'd0}, 1'b1);
      runBurst("t4b0", 18'd2560, 7'd0, 32'h0000_1000, 1'b0, 0, 1'b0, 1'b0);
      runBurst("t4b1", 18'd2568, 7'd8, 32'h0000_2000, 1'b0, 0, 1'b0, 1'b0);
      chk("t4b2_addr", {14'd0, o_memAddr}, 32'd2576);
      i_memAck = 1'b1;
      step();
      i_memAck = 1'b0;
      for (int n = 0; n < 3; n++) begin
         i_memValid = 1'b1;
         i_memData  = 32'h0000_3000 + 32'(n);
         step();
         chk("t4b2_idx", {25'd0, o_writeIdx128}, 32'd16 + 32'(n));
      end
      // reset wins over a coincident load command and data beat
      i_rst      = 1'b1;
      i_loadReq  = 1'b1;
      i_memData  = 32'h0000_3003;
      step();
      i_rst     = 1'b0;
      i_loadReq = 1'b0;
      chk("t4_rstBusy", {31'd0, o_busy},   32'd0);
      chk("t4_rstReq",  {31'd0, o_memReq}, 32'd0);
      chk("t4_rstWr",   {31'd0, o_write},  32'd0);
      chk("t4_rstAddr", {14'd0, o_memAddr}, 32'd0);
      chk("t4_rstIdx",  {25'd0, o_writeIdx128}, 32'd0);
      chk("t4_rstCol",  o_Colors, 32'd0);
      w0 = writesSeen;
      for (int n = 4; n < 8; n++) begin
         i_memData = 32'h0000_3000 + 32'(n);
         step();
         chk("t4_lateNoWr", {31'd0, o_write}, 32'd0);
      end
      i_memValid = 1'b0;
      chk("t4_lateWrites", 32'(writesSeen - w0), 32'd0);

      // Fresh 4bpp load after reset, Y=7 X=2 -> 3600, gapped beats
      startLoad({9'd7, 6'd2}, 1'b0);
      runBurst("t5", 18'd3600, 7'd0, 32'hC0DE_0000, 1'b1, 0, 1'b0, 1'b1);
      step();
      chk("t5_idle", {31'd0, o_busy}, 32'd0);
      chk("t5_done", {31'd0, o_done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
